// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures the decoded instruction word each cycle,
// with flush-to-bubble, freeze-to-hold and saturating bubble/stall counters.
module id_exe_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             clr_counters,

  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic             imm_in,
  input  logic [3:0]       exec_cmd_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] val_rn_in,
  input  logic [WIDTH-1:0] val_rm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic             carry_in,

  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic             imm_out,
  output logic [3:0]       exec_cmd_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] val_rn_out,
  output logic [WIDTH-1:0] val_rm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm_24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic             carry_out,

  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WORD_W = 6 + 4 + 3 * WIDTH + 12 + 24 + 12 + 1;

  logic [WORD_W-1:0] word_in;
  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] word_next;
  logic              valid_reg;
  logic              valid_next;

  // The whole decoded word travels as one vector so flush/freeze act on it uniformly.
  assign word_in = {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
                    exec_cmd_in, pc_in, val_rn_in, val_rm_in,
                    shift_operand_in, signed_imm_24_in,
                    dest_in, src1_in, src2_in, carry_in};

  always_comb begin
    word_next  = word_reg;
    valid_next = valid_reg;
    if (flush) begin
      word_next  = '0;
      valid_next = 1'b0;
    end else if (!freeze) begin
      word_next  = word_in;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      word_reg  <= word_next;
      valid_reg <= valid_next;
    end
  end

  assign {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
          exec_cmd_out, pc_out, val_rn_out, val_rm_out,
          shift_operand_out, signed_imm_24_out,
          dest_out, src1_out, src2_out, carry_out} = word_reg;

  assign valid_out = valid_reg;

  // Counter 0 counts flush bubbles; counter 1 counts freeze cycles not overridden by flush.
  logic [1:0] cnt_inc;
  assign cnt_inc[0] = flush;
  assign cnt_inc[1] = freeze & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : cnt_gen
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (clr_counters) begin
          cnt_next = '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  assign bubble_count = cnt_gen[0].cnt_reg;
  assign stall_count  = cnt_gen[1].cnt_reg;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: reset, load, freeze, flush, flush+freeze,
// counter saturation and clear, all with hand-computed expectations.
module tb_id_exe_reg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, freeze, clr_counters;
  logic             wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]       exec_cmd_in;
  logic [WIDTH-1:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0]      shift_operand_in;
  logic [23:0]      signed_imm_24_in;
  logic [3:0]       dest_in, src1_in, src2_in;
  logic             carry_in;

  logic             wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic [3:0]       exec_cmd_out;
  logic [WIDTH-1:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0]      shift_operand_out;
  logic [23:0]      signed_imm_24_out;
  logic [3:0]       dest_out, src1_out, src2_out;
  logic             carry_out, valid_out;
  logic [CNT_W-1:0] bubble_count, stall_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_exe_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .clr_counters(clr_counters),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exec_cmd_in(exec_cmd_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .exec_cmd_out(exec_cmd_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out),
    .valid_out(valid_out), .bubble_count(bubble_count), .stall_count(stall_count)
  );

  // Every output bit gathered together, for "everything is zero" checks.
  logic [255:0] all_out;
  assign all_out = {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
                    exec_cmd_out, pc_out, val_rn_out, val_rm_out, shift_operand_out,
                    signed_imm_24_out, dest_out, src1_out, src2_out, carry_out,
                    valid_out, bubble_count, stall_count};

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = '0;
    exec_cmd_in = '0; pc_in = '0; val_rn_in = '0; val_rm_in = '0;
    shift_operand_in = '0; signed_imm_24_in = '0;
    dest_in = '0; src1_in = '0; src2_in = '0; carry_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; clr_counters = 1'b0;
    idle_inputs();
    #1;
    check("reset_all_zero", all_out, '0);
    @(negedge clk);
    rst = 1'b0;

    // Full word load, then asynchronous reset mid-cycle.
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'b111111;
    exec_cmd_in = 4'hA; pc_in = 32'h1234_5678;
    val_rn_in = 32'hDEAD_BEEF; val_rm_in = 32'hCAFE_F00D;
    shift_operand_in = 12'hABC; signed_imm_24_in = 24'h123456;
    dest_in = 4'h1; src1_in = 4'h2; src2_in = 4'h3; carry_in = 1'b1;
    step();
    check("full_ctrl", {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out}, 6'b111111);
    check("full_cmd", exec_cmd_out, 4'hA);
    check("full_pc", pc_out, 32'h1234_5678);
    check("full_rn", val_rn_out, 32'hDEAD_BEEF);
    check("full_rm", val_rm_out, 32'hCAFE_F00D);
    check("full_shift", shift_operand_out, 12'hABC);
    check("full_imm24", signed_imm_24_out, 24'h123456);
    check("full_regs", {dest_out, src1_out, src2_out}, 12'h123);
    check("full_carry", carry_out, 1'b1);
    check("full_valid", valid_out, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_zero", all_out, '0);
    #1;
    rst = 1'b0;

    // Normal load.
    idle_inputs();
    exec_cmd_in = 4'b0010; wb_en_in = 1'b1; val_rn_in = 32'h5; dest_in = 4'd3;
    step();
    check("load_cmd", exec_cmd_out, 4'b0010);
    check("load_wb", wb_en_out, 1'b1);
    check("load_rn", val_rn_out, 32'h5);
    check("load_dest", dest_out, 4'd3);
    check("load_valid", valid_out, 1'b1);

    // Freeze for 3 cycles while inputs change.
    pc_in = 32'h10;
    step();
    check("pre_freeze_pc", pc_out, 32'h10);
    freeze = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pc_in = 32'h100 + k; exec_cmd_in = 4'(k + 4); val_rm_in = 32'hFFFF_0000 + k;
      step();
      check("freeze_pc", pc_out, 32'h10);
      check("freeze_cmd", exec_cmd_out, 4'b0010);
      check("freeze_stall", stall_count, 4'(k));
    end
    freeze = 1'b0;
    step();
    check("unfreeze_pc", pc_out, 32'h103);
    check("unfreeze_rm", val_rm_out, 32'hFFFF_0003);
    check("unfreeze_stall", stall_count, 4'd3);

    // Single flush.
    mem_w_en_in = 1'b1; b_in = 1'b1; flush = 1'b1;
    step();
    check("flush_word_zero", all_out[255:2*CNT_W], '0);
    check("flush_bubble", bubble_count, 4'd1);
    check("flush_stall", stall_count, 4'd3);
    flush = 1'b0;

    // Flush together with freeze for 2 cycles.
    idle_inputs();
    pc_in = 32'h20; exec_cmd_in = 4'h4;
    step();
    check("reload_valid", valid_out, 1'b1);
    flush = 1'b1; freeze = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      check("ff_word_zero", all_out[255:2*CNT_W], '0);
      check("ff_bubble", bubble_count, 4'(1 + k));
      check("ff_stall", stall_count, 4'd3);
    end
    flush = 1'b0; freeze = 1'b0;

    // Stall saturation, then clear while frozen.
    pc_in = 32'h44; exec_cmd_in = 4'h5;
    step();
    check("sat_load_pc", pc_out, 32'h44);
    freeze = 1'b1;
    pc_in = 32'h99;
    repeat (20) step();
    check("stall_saturated", stall_count, 4'hF);
    check("sat_hold_pc", pc_out, 32'h44);
    clr_counters = 1'b1;
    step();
    check("clr_stall", stall_count, 4'd0);
    check("clr_bubble", bubble_count, 4'd0);
    check("clr_hold_pc", pc_out, 32'h44);
    check("clr_hold_valid", valid_out, 1'b1);
    clr_counters = 1'b0;

    // Bubble saturation.
    freeze = 1'b0; flush = 1'b1;
    repeat (17) step();
    check("bubble_saturated", bubble_count, 4'hF);
    check("bubble_sat_stall", stall_count, 4'd0);
    flush = 1'b0;

    // Reset during a freeze clears immediately, nothing remembered.
    pc_in = 32'h77;
    step();
    freeze = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_freeze", all_out, '0);
    #1;
    rst = 1'b0;
    freeze = 1'b0;
    pc_in = 32'h88;
    step();
    check("post_rst_load_pc", pc_out, 32'h88);
    check("post_rst_counters", {bubble_count, stall_count}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
